// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: size encodings,
// FSM state type and the default data-memory size.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEF_MEM_BYTES = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } lsu_state_t;

  // Bytes moved by an access of the given size (illegal size reports 4;
  // such accesses are rejected before any beat is issued).
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load-result formatter: sign- or zero-extends the assembled little-endian
// load data according to the access size.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = raw;
    case (size)
      SZ_BYTE: rdata = {{24{sign_ext & raw[7]}}, raw[7:0]};
      SZ_HALF: rdata = {{16{sign_ext & raw[15]}}, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: one CPU access becomes 1, 2 or 4 byte beats
// on an asynchronous-read byte memory, little-endian.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [1:0]  state_dbg
);

  // Handshake: req is sampled only in IDLE (busy=0); the access ends with a
  // single-cycle done (with err for rejected accesses), after which busy drops.

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  lsu_state_t  state_q, state_d;
  logic [1:0]  beat_q;
  logic        we_q, sext_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, raw_q, rdata_q, ext_out;
  logic [2:0]  n_in, n_q;
  logic [1:0]  last_beat;
  logic        legal_in, aligned_in;
  logic [32:0] end_in;

  assign n_in = size_bytes(size);
  assign n_q  = size_bytes(size_q);
  assign last_beat = n_q[1:0] - 2'd1;

  // 33-bit end address so accesses wrapping past 0xFFFFFFFF are rejected.
  assign end_in = {1'b0, addr} + {30'b0, n_in};

  always_comb begin
    aligned_in = 1'b1;
    case (size)
      SZ_HALF: aligned_in = ~addr[0];
      SZ_WORD: aligned_in = (addr[1:0] == 2'b00);
      default: aligned_in = 1'b1;
    endcase
  end

  assign legal_in = (size != 2'b11) && aligned_in && (end_in <= MEM_LIMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req) state_d = legal_in ? ST_ACCESS : ST_DONE;
      ST_ACCESS: if (beat_q == last_beat) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      raw_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            sext_q  <= sign_ext;
            addr_q  <= addr;
            wdata_q <= wdata;
            err_q   <= ~legal_in;
            beat_q  <= 2'd0;
            raw_q   <= 32'd0;
          end
        end
        ST_ACCESS: begin
          if (!we_q) raw_q[{beat_q, 3'b000} +: 8] <= mem_rdata;
          beat_q <= beat_q + 2'd1;
        end
        ST_DONE: begin
          if (!we_q && !err_q) rdata_q <= ext_out;
        end
        default: ;
      endcase
    end
  end

  lsu_extend u_extend (
    .raw      (raw_q),
    .size     (size_q),
    .sign_ext (sext_q),
    .rdata    (ext_out)
  );

  // Strobes are gated by rst so a reset during a beat cancels that beat's write.
  assign mem_re    = (state_q == ST_ACCESS) && !we_q && !rst;
  assign mem_we    = (state_q == ST_ACCESS) && we_q && !rst;
  assign mem_addr  = (state_q == ST_ACCESS) ? addr_q + {30'b0, beat_q} : 32'd0;
  assign mem_wdata = (state_q == ST_ACCESS) ? wdata_q[{beat_q, 3'b000} +: 8] : 8'd0;

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign err   = (state_q == ST_DONE) && err_q;
  assign rdata = (state_q == ST_DONE && !we_q && !err_q) ? ext_out : rdata_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level memory
// model, plus directed store/load, illegal-access and mid-access reset cases.
module tb_load_store_unit;

  localparam int MEM_BYTES = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err, mem_re, mem_we;
  logic [31:0] rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [1:0]  state_dbg;

  logic [7:0]  mem [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] exp_q [$];
  logic [31:0] last_rdata = 32'd0;
  logic [31:0] last_got = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // clock / environment memory
  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < MEM_BYTES) ? mem[mem_addr[6:0]] : 8'h00;

  always @(posedge clk)
    if (mem_we && mem_addr < MEM_BYTES) mem[mem_addr[6:0]] <= mem_wdata;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit legal_model(input logic [1:0] sz, input logic [31:0] a);
    longint n;
    n = longint'(nbytes(sz));
    if (sz == 2'd3) return 1'b0;
    if ((longint'({32'b0, a}) % n) != 0) return 1'b0;
    if (longint'({32'b0, a}) + n > longint'(MEM_BYTES)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] load_model(input logic [1:0] sz, input logic sx, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v + (32'(ref_mem[int'(a) + k]) << (8 * k));
    if (sx && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // driver: one access, checked beat by beat
  task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd, input bit junk);
    int n, cyc, nre, nwe;
    bit ok, got_done;
    logic [31:0] exp;
    n  = nbytes(sz);
    ok = legal_model(sz, a);
    if (ok && w) for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8 * k +: 8];
    if (ok && !w) begin
      exp = load_model(sz, sx, a);
      last_rdata = exp;
    end else begin
      exp = last_rdata;
    end
    exp_q.push_back(exp);

    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    cyc = 1; nre = 0; nwe = 0; got_done = 1'b0;
    while (!got_done && cyc <= 8) begin
      check("busy_during", 32'(busy), 32'd1);
      check("strobe_excl", 32'(mem_re & mem_we), 32'd0);
      if (mem_re || mem_we) begin
        check("mem_addr", mem_addr, a + 32'(cyc - 1));
        if (mem_we && cyc <= 4) check("mem_wdata", 32'(mem_wdata), 32'(wd[8 * (cyc - 1) +: 8]));
        nre += int'(mem_re);
        nwe += int'(mem_we);
      end
      if (done) begin
        got_done = 1'b1;
        req = 1'b0;
        check("err", 32'(err), ok ? 32'd0 : 32'd1);
        check("rdata_done", rdata, exp_q.pop_front());
        last_got = rdata;
      end else begin
        if (junk) begin
          req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
          addr = $urandom_range(0, MEM_BYTES - 1); wdata = $urandom;
          size = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        cyc++;
      end
    end
    req = 1'b0;
    if (!got_done) void'(exp_q.pop_front());
    check("done_seen", 32'(got_done), 32'd1);
    check("latency", 32'(cyc), ok ? 32'(n + 1) : 32'd1);
    check("n_we", 32'(nwe), (ok && w) ? 32'(n) : 32'd0);
    check("n_re", 32'(nre), (ok && !w) ? 32'(n) : 32'd0);
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("done_after", 32'(done), 32'd0);
    check("rdata_hold", rdata, exp);
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;

    // directed store and loads
    do_access(1'b1, 2'd2, 1'b0, 32'd8, 32'h8899AABB, 1'b0);
    do_access(1'b0, 2'd0, 1'b1, 32'd9, 32'd0, 1'b0);
    check("ld_b9_sext", last_got, 32'hFFFFFFAA);
    do_access(1'b0, 2'd0, 1'b0, 32'd9, 32'd0, 1'b0);
    check("ld_b9_zext", last_got, 32'h000000AA);
    do_access(1'b0, 2'd1, 1'b1, 32'd10, 32'd0, 1'b0);
    check("ld_h10_sext", last_got, 32'hFFFF8899);
    do_access(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, 1'b1);
    check("ld_w8", last_got, 32'h8899AABB);

    // illegal accesses leave rdata at the last load result
    do_access(1'b0, 2'd2, 1'b0, 32'd6, 32'd0, 1'b0);
    do_access(1'b1, 2'd1, 1'b0, 32'd3, 32'h1234, 1'b0);
    do_access(1'b1, 2'd2, 1'b0, 32'd126, 32'hCAFEF00D, 1'b0);
    do_access(1'b0, 2'd3, 1'b0, 32'd0, 32'd0, 1'b0);
    do_access(1'b0, 2'd0, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0);
    check("illegal_keep", last_got, 32'h8899AABB);

    // reset during beat 2 of a word store
    do_access(1'b1, 2'd2, 1'b0, 32'd20, 32'h00000000, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'd20; wdata = 32'hDEADBEEF;
    @(negedge clk);
    req = 1'b0;
    check("abort_done0", 32'(done), 32'd0);
    @(negedge clk);
    check("abort_done1", 32'(done), 32'd0);
    @(negedge clk);
    check("abort_beat2_addr", mem_addr, 32'd22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    ref_mem[20] = 8'hEF;
    ref_mem[21] = 8'hBE;
    last_rdata = 32'd0;
    do_access(1'b0, 2'd2, 1'b0, 32'd20, 32'd0, 1'b0);
    check("abort_partial", last_got, 32'h0000BEEF);

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
      else a = 32'($urandom_range(0, MEM_BYTES + 3));
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
